// File: rtl/bht_access_ctrl_if.sv
// Fetch/execute/BHT-port signal bundle for the BHT access sequencer.
// master = requester/RAM side, slave = the sequencer itself.
interface bht_access_ctrl_if #(
  parameter int HIST_W = 2,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pred_req;
  logic              pred_ack;
  logic              pred_taken;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              resolve_ack;
  logic              mispredict;
  logic              resolve_err;
  logic              flush;
  logic              bht_en;
  logic              bht_we;
  logic [HIST_W-1:0] bht_idx;
  logic [1:0]        bht_wdata;
  logic [1:0]        bht_rdata;
  logic [HIST_W-1:0] history;
  logic [CNT_W-1:0]  inflight;
  logic              busy;

  modport master (
    output pred_req, resolve_valid, resolve_taken, flush, bht_rdata,
    input  pred_ack, pred_taken, resolve_ack, mispredict, resolve_err,
           bht_en, bht_we, bht_idx, bht_wdata, history, inflight, busy
  );

  modport slave (
    input  pred_req, resolve_valid, resolve_taken, flush, bht_rdata,
    output pred_ack, pred_taken, resolve_ack, mispredict, resolve_err,
           bht_en, bht_we, bht_idx, bht_wdata, history, inflight, busy
  );
endinterface

// File: rtl/bht_access_ctrl.sv
// Single-port BHT sequencer: lookups, read-modify-write updates, in-order prediction queue, global history.
// Latency: pred_ack and resolve_ack one cycle after acceptance; requests held until acked, full queue stalls pred_req.
module bht_access_ctrl #(
  parameter int HIST_W = 2,
  parameter int DEPTH  = 4
) (
  input logic               clk,
  input logic               reset,
  bht_access_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] UPD_RD = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [HIST_W-1:0] q_idx  [DEPTH];
  logic              q_pred [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [HIST_W-1:0] history_q, lat_idx;

  logic              push, pop, lat_en;
  logic              pred_ack_c, pred_taken_c, resolve_ack_c, mispredict_c, resolve_err_c;
  logic              bht_en_c, bht_we_c, busy_c;
  logic [HIST_W-1:0] bht_idx_c;
  logic [1:0]        bht_wdata_c;

  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Outputs are forced low while reset is held, independent of inputs.
  always_comb begin
    state_nxt     = state;
    push          = 1'b0;
    pop           = 1'b0;
    lat_en        = 1'b0;
    pred_ack_c    = 1'b0;
    pred_taken_c  = 1'b0;
    resolve_ack_c = 1'b0;
    mispredict_c  = 1'b0;
    resolve_err_c = 1'b0;
    bht_en_c      = 1'b0;
    bht_we_c      = 1'b0;
    bht_idx_c     = '0;
    bht_wdata_c   = 2'b00;
    busy_c        = 1'b0;
    if (reset) begin
      busy_c = (state != IDLE);
      case (state)
        IDLE: begin
          if (!bus.flush) begin
            if (bus.resolve_valid && count != '0) begin
              bht_en_c  = 1'b1;
              bht_idx_c = q_idx[head];
              state_nxt = UPD_RD;
            end else if (bus.resolve_valid) begin
              resolve_ack_c = 1'b1;
              resolve_err_c = 1'b1;
            end else if (bus.pred_req && count < DEPTH_C) begin
              bht_en_c  = 1'b1;
              bht_idx_c = history_q;
              lat_en    = 1'b1;
              state_nxt = LOOKUP;
            end
          end
        end
        LOOKUP: begin
          state_nxt = IDLE;
          if (!bus.flush) begin
            pred_ack_c   = 1'b1;
            pred_taken_c = bus.bht_rdata[1];
            push         = 1'b1;
          end
        end
        UPD_RD: begin
          bht_en_c      = 1'b1;
          bht_we_c      = 1'b1;
          bht_idx_c     = q_idx[head];
          bht_wdata_c   = sat_upd(bus.bht_rdata, bus.resolve_taken);
          resolve_ack_c = 1'b1;
          mispredict_c  = (bus.resolve_taken != q_pred[head]);
          pop           = 1'b1;
          state_nxt     = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      history_q <= '0;
      lat_idx   <= '0;
    end else begin
      state <= state_nxt;
      if (lat_en) lat_idx <= history_q;
      if (pop) history_q <= {history_q[HIST_W-2:0], bus.resolve_taken};
      // Flush wins over any same-cycle pop: the queue restarts empty.
      if (bus.flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          tail  <= ptr_inc(tail);
          count <= count + CW'(1);
        end else if (pop) begin
          head  <= ptr_inc(head);
          count <= count - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[tail]  <= lat_idx;
      q_pred[tail] <= pred_taken_c;
    end
  end

  assign bus.pred_ack    = pred_ack_c;
  assign bus.pred_taken  = pred_taken_c;
  assign bus.resolve_ack = resolve_ack_c;
  assign bus.mispredict  = mispredict_c;
  assign bus.resolve_err = resolve_err_c;
  assign bus.bht_en      = bht_en_c;
  assign bus.bht_we      = bht_we_c;
  assign bus.bht_idx     = bht_idx_c;
  assign bus.bht_wdata   = bht_wdata_c;
  assign bus.busy        = busy_c;
  assign bus.history     = history_q;
  assign bus.inflight    = count;
endmodule

// File: tb/tb_bht_access_ctrl.sv
// Directed + randomized bench for bht_access_ctrl with a queue-based reference model and a behavioural BHT RAM.
module tb_bht_access_ctrl;
  logic clk;
  logic reset;

  bht_access_ctrl_if #(.HIST_W(2), .DEPTH(4)) bus ();

  bht_access_ctrl #(.HIST_W(2), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    logic       pred;
  } ent_t;

  ent_t q[$];
  int   model[4];
  int   mem[4];
  int   hist;
  int   n_cmp;
  int   n_err;

  function automatic int sat(int c, bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; the RAM sees the bus as it stood just before the edge.
  task automatic step();
    logic       en, we;
    logic [1:0] ix, wd;
    en = bus.bht_en; we = bus.bht_we; ix = bus.bht_idx; wd = bus.bht_wdata;
    @(posedge clk); #1;
    if (en && !we) bus.bht_rdata = 2'(mem[ix]);
    if (en && we)  mem[ix] = int'(wd);
  endtask

  task automatic push_model();
    ent_t e;
    e.idx  = 2'(hist);
    e.pred = model[hist][1];
    q.push_back(e);
  endtask

  task automatic do_pred();
    bus.pred_req = 1'b1;
    @(negedge clk);
    chk("pred_rd_en", bus.bht_en, 1);
    chk("pred_rd_we", bus.bht_we, 0);
    chk("pred_rd_idx", bus.bht_idx, hist);
    chk("pred_rd_noack", bus.pred_ack, 0);
    step();
    @(negedge clk);
    chk("pred_ack", bus.pred_ack, 1);
    chk("pred_taken", bus.pred_taken, model[hist] >> 1);
    chk("lookup_busy", bus.busy, 1);
    chk("lookup_no_bht", bus.bht_en, 0);
    push_model();
    step();
    bus.pred_req = 1'b0;
    chk("inflight_pred", bus.inflight, q.size());
  endtask

  task automatic upd_phase(bit t);
    ent_t e;
    int   exp_w;
    e = q[0];
    exp_w = sat(model[e.idx], t);
    @(negedge clk);
    chk("upd_en", bus.bht_en, 1);
    chk("upd_we", bus.bht_we, 1);
    chk("upd_idx", bus.bht_idx, e.idx);
    chk("upd_wdata", bus.bht_wdata, exp_w);
    chk("upd_ack", bus.resolve_ack, 1);
    chk("upd_mispredict", bus.mispredict, (t != e.pred) ? 1 : 0);
    chk("upd_err", bus.resolve_err, 0);
    chk("upd_busy", bus.busy, 1);
    model[e.idx] = exp_w;
    hist = ((hist << 1) | int'(t)) & 3;
    void'(q.pop_front());
  endtask

  task automatic do_resolve(bit t);
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = t;
    @(negedge clk);
    if (q.size() == 0) begin
      chk("err_ack", bus.resolve_ack, 1);
      chk("err_flag", bus.resolve_err, 1);
      chk("err_no_bht", bus.bht_en, 0);
      step();
      bus.resolve_valid = 1'b0;
      chk("err_hist", bus.history, hist);
      chk("err_busy", bus.busy, 0);
    end else begin
      chk("res_rd_en", bus.bht_en, 1);
      chk("res_rd_we", bus.bht_we, 0);
      chk("res_rd_idx", bus.bht_idx, q[0].idx);
      chk("res_rd_noack", bus.resolve_ack, 0);
      step();
      upd_phase(t);
      step();
      bus.resolve_valid = 1'b0;
      chk("res_hist", bus.history, hist);
      chk("res_inflight", bus.inflight, q.size());
    end
  endtask

  // pred_req and resolve_valid together; queue must be non-empty.
  task automatic do_both(bit t);
    bus.pred_req      = 1'b1;
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = t;
    @(negedge clk);
    chk("both_rd_idx", bus.bht_idx, q[0].idx);
    chk("both_rd_we", bus.bht_we, 0);
    chk("both_no_pack", bus.pred_ack, 0);
    step();
    upd_phase(t);
    chk("both_no_pack2", bus.pred_ack, 0);
    step();
    bus.resolve_valid = 1'b0;
    @(negedge clk);
    chk("both_prd_en", bus.bht_en, 1);
    chk("both_prd_idx", bus.bht_idx, hist);
    chk("both_prd_noack", bus.resolve_ack, 0);
    step();
    @(negedge clk);
    chk("both_pack", bus.pred_ack, 1);
    chk("both_ptaken", bus.pred_taken, model[hist] >> 1);
    push_model();
    step();
    bus.pred_req = 1'b0;
    chk("both_inflight", bus.inflight, q.size());
  endtask

  initial begin
    int init_tbl[4];
    init_tbl = '{1, 3, 0, 2};
    n_cmp = 0; n_err = 0; hist = 0;
    clk = 1'b0;
    reset = 1'b0;
    bus.pred_req = 1'b1;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.flush = 1'b0;
    bus.bht_rdata = 2'b00;
    for (int i = 0; i < 4; i++) begin
      model[i] = init_tbl[i];
      mem[i]   = init_tbl[i];
    end

    // Reset state, with a request held to prove outputs stay gated.
    @(negedge clk);
    chk("rst_pred_ack", bus.pred_ack, 0);
    chk("rst_bht_en", bus.bht_en, 0);
    chk("rst_bht_idx", bus.bht_idx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_inflight", bus.inflight, 0);
    chk("rst_history", bus.history, 0);
    step();
    bus.pred_req = 1'b0;
    reset = 1'b1;

    // Basic predict/resolve and saturation walk: idx 0,1,3,2.
    do_pred();
    do_resolve(1'b1);
    do_pred();
    do_resolve(1'b1);
    do_pred();
    do_resolve(1'b0);
    do_pred();
    do_resolve(1'b0);

    // Fill queue, then a held 5th request must stall.
    for (int i = 0; i < 4; i++) do_pred();
    chk("full_inflight", bus.inflight, 4);
    bus.pred_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_stall_en", bus.bht_en, 0);
      chk("full_stall_ack", bus.pred_ack, 0);
      step();
    end
    do_both(1'b1);
    for (int i = 0; i < 4; i++) do_resolve(1'b0);
    do_resolve(1'b1);

    // Flush during LOOKUP, with entries already queued.
    do_pred();
    do_pred();
    bus.pred_req = 1'b1;
    @(negedge clk);
    chk("fl_lk_rd", bus.bht_en, 1);
    step();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_lk_noack", bus.pred_ack, 0);
    chk("fl_lk_ptaken", bus.pred_taken, 0);
    step();
    bus.flush = 1'b0;
    bus.pred_req = 1'b0;
    q.delete();
    chk("fl_lk_inflight", bus.inflight, 0);
    chk("fl_lk_busy", bus.busy, 0);

    // Flush in IDLE blocks a pending resolve.
    do_pred();
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_idle_en", bus.bht_en, 0);
    chk("fl_idle_ack", bus.resolve_ack, 0);
    step();
    bus.flush = 1'b0;
    bus.resolve_valid = 1'b0;
    q.delete();
    chk("fl_idle_inflight", bus.inflight, 0);
    chk("fl_idle_hist", bus.history, hist);

    // Flush in UPD_RD: write still lands, queue then empties.
    do_pred();
    do_pred();
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b0;
    @(negedge clk);
    step();
    bus.flush = 1'b1;
    upd_phase(1'b0);
    step();
    bus.flush = 1'b0;
    bus.resolve_valid = 1'b0;
    q.delete();
    chk("fl_upd_inflight", bus.inflight, 0);
    chk("fl_upd_hist", bus.history, hist);

    // Reset asserted while in UPD_RD: no write, outputs all zero.
    do_pred();
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b1;
    @(negedge clk);
    step();
    bus.pred_req = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_en", bus.bht_en, 0);
    chk("rmid_we", bus.bht_we, 0);
    chk("rmid_wdata", bus.bht_wdata, 0);
    chk("rmid_ack", bus.resolve_ack, 0);
    chk("rmid_misp", bus.mispredict, 0);
    chk("rmid_busy", bus.busy, 0);
    chk("rmid_inflight", bus.inflight, 0);
    chk("rmid_hist", bus.history, 0);
    step();
    chk("rmid_nowrite", mem[q[0].idx], model[q[0].idx]);
    bus.pred_req = 1'b0;
    bus.resolve_valid = 1'b0;
    reset = 1'b1;
    q.delete();
    hist = 0;

    // Randomized phase over a fresh random table.
    for (int i = 0; i < 4; i++) begin
      model[i] = int'($urandom_range(0, 3));
      mem[i]   = model[i];
    end
    for (int n = 0; n < 120; n++) begin
      int r;
      r = int'($urandom_range(0, 5));
      if (r < 3 && q.size() < 4) do_pred();
      else if (r == 3 && q.size() > 0) do_both(1'($urandom_range(0, 1)));
      else do_resolve(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) chk("final_tbl", mem[i], model[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
